// File: rtl/vector_slide_pkg.sv
// Shared types and sizing helpers for the vector slide/permute unit.
package vector_slide_pkg;

  typedef enum logic [1:0] {
    SLIDEUP    = 2'd0,
    SLIDEDOWN  = 2'd1,
    SLIDE1UP   = 2'd2,
    SLIDE1DOWN = 2'd3
  } slide_op_t;

  localparam int unsigned DEFAULT_LANES = 16;
  localparam int unsigned LANE_IDX_W    = $clog2(DEFAULT_LANES);

  // One extra bit so a shift of exactly the lane count is representable.
  function automatic int unsigned shamt_width(input int unsigned lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/vector_slide_net.sv
// Combinational logarithmic lane slide; also reports which output lanes
// received a real source element versus fill.
module vector_slide_net
  import vector_slide_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int VECTOR_LANES = 16,
  parameter int SHAMT_W      = 5
) (
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec,
  input  logic                               down,
  input  logic [SHAMT_W-1:0]                 amount,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_out,
  output logic [VECTOR_LANES-1:0]            src_valid
);

  localparam int VW = VECTOR_LANES * DATA_WIDTH;

  logic [VW-1:0]           v [SHAMT_W+1];
  logic [VECTOR_LANES-1:0] m [SHAMT_W+1];

  assign v[0] = vec;
  assign m[0] = '1;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int D = 1 << s;
    if (D >= VECTOR_LANES) begin : g_flush
      // Top stage moves every lane out of range.
      assign v[s+1] = amount[s] ? '0 : v[s];
      assign m[s+1] = amount[s] ? '0 : m[s];
    end else begin : g_shift
      assign v[s+1] = !amount[s] ? v[s] :
                      down ? (v[s] >> (D*DATA_WIDTH)) : (v[s] << (D*DATA_WIDTH));
      assign m[s+1] = !amount[s] ? m[s] :
                      down ? (m[s] >> D) : (m[s] << D);
    end
  end

  assign vec_out   = v[SHAMT_W];
  assign src_valid = m[SHAMT_W];

endmodule

// File: rtl/vector_slide_pipe.sv
// Elastic two-stage slide/permute unit: operand register, shift network,
// then scalar insertion and mask merge into the result register.
module vector_slide_pipe
  import vector_slide_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int VECTOR_LANES = 16,
  parameter int OFFSET_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [1:0]                         in_op,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] in_vs2,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] in_vd_old,
  input  logic [OFFSET_WIDTH-1:0]            in_offset,
  input  logic [DATA_WIDTH-1:0]              in_scalar,
  input  logic                               in_mask_en,
  input  logic [VECTOR_LANES-1:0]            in_mask,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] out_vd
);

  localparam int VW      = VECTOR_LANES * DATA_WIDTH;
  localparam int SHAMT_W = shamt_width(VECTOR_LANES);

  function automatic logic [SHAMT_W-1:0] sat_offset(input slide_op_t op,
                                                   input logic [OFFSET_WIDTH-1:0] offset);
    logic [OFFSET_WIDTH:0] wide;
    wide = {1'b0, offset};
    if (op == SLIDE1UP || op == SLIDE1DOWN) return SHAMT_W'(1);
    if (wide >= (OFFSET_WIDTH+1)'(VECTOR_LANES)) return SHAMT_W'(VECTOR_LANES);
    return SHAMT_W'(wide);
  endfunction

  logic                    s1_adv, s2_adv;
  logic                    vld_p1;
  slide_op_t               op_p1;
  logic [VW-1:0]           vs2_p1, vd_old_p1;
  logic [SHAMT_W-1:0]      amt_p1;
  logic [DATA_WIDTH-1:0]   scalar_p1;
  logic [VECTOR_LANES-1:0] mask_p1;

  logic [VW-1:0]           net_out;
  logic [VECTOR_LANES-1:0] src_valid;
  logic [VW-1:0]           merged;
  logic [DATA_WIDTH-1:0]   lane_res;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (s1_adv) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      op_p1     <= slide_op_t'(in_op);
      vs2_p1    <= in_vs2;
      vd_old_p1 <= in_vd_old;
      amt_p1    <= sat_offset(slide_op_t'(in_op), in_offset);
      scalar_p1 <= in_scalar;
      mask_p1   <= in_mask_en ? in_mask : '1;
    end
  end

  vector_slide_net #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VECTOR_LANES(VECTOR_LANES),
    .SHAMT_W     (SHAMT_W)
  ) u_net (
    .vec      (vs2_p1),
    .down     (op_p1 == SLIDEDOWN || op_p1 == SLIDE1DOWN),
    .amount   (amt_p1),
    .vec_out  (net_out),
    .src_valid(src_valid)
  );

  // Lanes with no source take vd_old (up), zero (down) or the scalar (slide1).
  always_comb begin
    merged   = vd_old_p1;
    lane_res = '0;
    for (int i = 0; i < VECTOR_LANES; i++) begin
      lane_res = net_out[i*DATA_WIDTH +: DATA_WIDTH];
      if (!src_valid[i]) begin
        case (op_p1)
          SLIDEUP:   lane_res = vd_old_p1[i*DATA_WIDTH +: DATA_WIDTH];
          SLIDEDOWN: lane_res = '0;
          default:   lane_res = scalar_p1;
        endcase
      end
      if (mask_p1[i]) merged[i*DATA_WIDTH +: DATA_WIDTH] = lane_res;
    end
  end

  // ---- stage 2: result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vd    <= '0;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) out_vd <= merged;
    end
  end

endmodule

// File: tb/tb_vector_slide_pipe.sv
// Directed table plus sequence and random-stream bench for vector_slide_pipe.
module tb_vector_slide_pipe;

  localparam int W  = 32;
  localparam int L  = 16;
  localparam int OW = 8;
  localparam int VW = W * L;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [VW-1:0] in_vs2;
  logic [VW-1:0] in_vd_old;
  logic [OW-1:0] in_offset;
  logic [W-1:0]  in_scalar;
  logic          in_mask_en;
  logic [L-1:0]  in_mask;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vd;

  always #5 clk = ~clk;

  vector_slide_pipe #(.DATA_WIDTH(W), .VECTOR_LANES(L), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_vs2(in_vs2), .in_vd_old(in_vd_old), .in_offset(in_offset), .in_scalar(in_scalar),
    .in_mask_en(in_mask_en), .in_mask(in_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_vd(out_vd)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit gap_chk = 0;
  bit have_last = 0;
  bit rand_rdy = 0;
  int last_cyc = 0;
  int n_out = 0;
  logic [VW-1:0] exp_q[$];

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [7:0]    off;
    logic [31:0]   sc;
    logic          me;
    logic [15:0]   m;
    logic [VW-1:0] exp;
  } vec_t;
  vec_t tbl[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] model(input logic [1:0] op, input logic [7:0] off,
      input logic [31:0] sc, input logic me, input logic [15:0] m,
      input logic [VW-1:0] vs2, input logic [VW-1:0] vd);
    logic [VW-1:0] r;
    logic [31:0] e;
    int k;
    k = (op >= 2) ? 1 : ((int'(off) > L) ? L : int'(off));
    for (int i = 0; i < L; i++) begin
      case (op)
        2'd0: e = (i >= k) ? vs2[(i-k)*W +: W] : vd[i*W +: W];
        2'd1: e = (i + k < L) ? vs2[(i+k)*W +: W] : 32'd0;
        2'd2: e = (i == 0) ? sc : vs2[(i-1)*W +: W];
        default: e = (i == L-1) ? sc : vs2[(i+1)*W +: W];
      endcase
      r[i*W +: W] = (!me || m[i]) ? e : vd[i*W +: W];
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [7:0] off, input logic [31:0] sc,
      input logic me, input logic [15:0] m, input logic [VW-1:0] vs2,
      input logic [VW-1:0] vd, output int waits);
    bit acc;
    in_op = op; in_offset = off; in_scalar = sc; in_mask_en = me; in_mask = m;
    in_vs2 = vs2; in_vd_old = vd; in_valid = 1'b1;
    waits = 0;
    acc = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      if (waits > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required accept", waits);
        break;
      end
    end
    if (acc && mon_en) exp_q.push_back(model(op, off, sc, me, m, vs2, vd));
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check_int("drain_pending", exp_q.size(), 0);
  endtask

  // Scoreboard: every transfer at the output is checked in order.
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_output: got %h with no op outstanding", out_vd);
      end else begin
        check_vec("stream", out_vd, exp_q.pop_front());
      end
      if (gap_chk && have_last) check_int("b2b_gap", cyc - last_cyc, 1);
      last_cyc = cyc;
      have_last = 1;
      n_out++;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] vinc, vaa, e, vs2, vd, held;
    logic [1:0]  rop;
    logic [7:0]  roff;
    logic [31:0] rsc;
    logic        rme;
    logic [15:0] rm;
    int waits, lat, stale;

    rst = 1; in_valid = 0; out_ready = 1; in_op = 0; in_vs2 = '0; in_vd_old = '0;
    in_offset = 0; in_scalar = 0; in_mask_en = 0; in_mask = '0;

    for (int i = 0; i < L; i++) begin
      vinc[i*W +: W] = 32'(i + 100);
      vaa[i*W +: W]  = 32'hAA;
    end

    for (int i = 0; i < L; i++) e[i*W +: W] = (i < 3) ? 32'hAA : 32'(i + 97);
    tbl[0] = '{"su_off3", 2'd0, 8'd3, 32'h0, 1'b0, 16'h0, e};
    for (int i = 0; i < L; i++) e[i*W +: W] = (i <= 10) ? 32'(i + 105) : 32'h0;
    tbl[1] = '{"sd_off5", 2'd1, 8'd5, 32'h0, 1'b0, 16'h0, e};
    tbl[2] = '{"sd_off200", 2'd1, 8'd200, 32'h0, 1'b0, 16'h0, '0};
    tbl[3] = '{"sd_off0", 2'd1, 8'd0, 32'h0, 1'b0, 16'h0, vinc};
    for (int i = 0; i < L; i++) e[i*W +: W] = (i == 0) ? 32'hDEAD : (i < 8) ? 32'(i + 99) : 32'hAA;
    tbl[4] = '{"s1u_mask", 2'd2, 8'd0, 32'hDEAD, 1'b1, 16'h00FF, e};
    tbl[5] = '{"su_off16", 2'd0, 8'd16, 32'h0, 1'b0, 16'h0, vaa};
    tbl[6] = '{"su_off255", 2'd0, 8'd255, 32'h0, 1'b0, 16'h0, vaa};
    for (int i = 0; i < L; i++) e[i*W +: W] = (i < 15) ? 32'(i + 101) : 32'hBEEF;
    tbl[7] = '{"s1d_off_ignored", 2'd3, 8'd9, 32'hBEEF, 1'b0, 16'h0, e};
    for (int i = 0; i < L; i++) e[i*W +: W] = ((i % 8) < 4) ? 32'h0 : 32'hAA;
    tbl[8] = '{"sd_off17_mask", 2'd1, 8'd17, 32'h0, 1'b1, 16'h0F0F, e};
    for (int i = 0; i < L; i++) e[i*W +: W] = (i >= 12) ? 32'(i + 100) : 32'hAA;
    tbl[9] = '{"su_off0_mask", 2'd0, 8'd0, 32'h0, 1'b1, 16'hF000, e};
    for (int i = 0; i < L; i++) e[i*W +: W] = (i == 15) ? 32'd100 : 32'hAA;
    tbl[10] = '{"su_off15", 2'd0, 8'd15, 32'h0, 1'b0, 16'h0, e};
    tbl[11] = '{"sd_off16", 2'd1, 8'd16, 32'h0, 1'b0, 16'h0, '0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_out_valid", int'(out_valid), 0);
    check_vec("rst_out_vd", out_vd, '0);
    rst = 0;
    @(posedge clk); #1;
    check_int("post_rst_in_ready", int'(in_ready), 1);

    // Directed table, one op at a time
    for (int t = 0; t < 12; t++) begin
      send(tbl[t].op, tbl[t].off, tbl[t].sc, tbl[t].me, tbl[t].m, vinc, vaa, waits);
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check_int({tbl[t].name, "_latency"}, lat, 2);
      check_vec(tbl[t].name, out_vd, tbl[t].exp);
      @(posedge clk); #1;
    end

    // Back-to-back: 8 ops, full throughput
    mon_en = 1; gap_chk = 1; have_last = 0; n_out = 0; out_ready = 1;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < L; i++) begin
        vs2[i*W +: W] = 32'(j * 256 + i);
        vd[i*W +: W]  = 32'(j + 32'h1000);
      end
      send(2'(j % 4), 8'(j), 32'(32'h5000 + j), 1'b0, 16'h0, vs2, vd, waits);
      check_int("b2b_accept_wait", waits, 0);
    end
    drain(20);
    check_int("b2b_count", n_out, 8);
    gap_chk = 0;

    // Stall with full pipe
    n_out = 0; out_ready = 0;
    send(2'd0, 8'd2, 32'h0, 1'b0, 16'h0, vinc, vaa, waits);
    send(2'd1, 8'd1, 32'h0, 1'b0, 16'h0, vinc, vaa, waits);
    held = model(2'd0, 8'd2, 32'h0, 1'b0, 16'h0, vinc, vaa);
    in_op = 2'd2; in_offset = 0; in_scalar = 32'h77; in_mask_en = 0; in_mask = '0;
    in_vs2 = vinc; in_vd_old = vaa; in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_int("stall_in_ready", int'(in_ready), 0);
      check_int("stall_out_valid", int'(out_valid), 1);
      check_vec("stall_out_vd", out_vd, held);
      @(posedge clk); #1;
    end
    exp_q.push_back(model(2'd2, 8'd0, 32'h77, 1'b0, 16'h0, vinc, vaa));
    out_ready = 1;
    @(negedge clk);
    check_int("unstall_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
    drain(20);
    check_int("stall_count", n_out, 3);

    // Reset with two ops in flight
    mon_en = 0; out_ready = 0;
    send(2'd0, 8'd1, 32'h0, 1'b0, 16'h0, vinc, vaa, waits);
    send(2'd3, 8'd0, 32'h9, 1'b0, 16'h0, vinc, vaa, waits);
    rst = 1;
    @(posedge clk); #1;
    check_int("midrst_out_valid", int'(out_valid), 0);
    check_vec("midrst_out_vd", out_vd, '0);
    rst = 0; out_ready = 1;
    @(posedge clk); #1;
    check_int("midrst_in_ready", int'(in_ready), 1);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_int("midrst_no_stale", stale, 0);
    exp_q.delete();

    // Random stream against the model with random backpressure
    mon_en = 1; rand_rdy = 1;
    @(posedge clk); #1;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < L; i++) begin
        vs2[i*W +: W] = $urandom();
        vd[i*W +: W]  = $urandom();
      end
      rop  = 2'($urandom_range(0, 3));
      roff = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 17));
      rsc  = $urandom();
      rme  = 1'($urandom_range(0, 1));
      rm   = 16'($urandom());
      send(rop, roff, rsc, rme, rm, vs2, vd, waits);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1;
    drain(50);
    mon_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
